// File: rtl/aes_sbox_sched_pkg.sv
// rtl/aes_sbox_sched_pkg.sv - shared types and constants for the masked S-box byte scheduler
package aes_sbox_sched_pkg;

  localparam int DEFAULT_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/aes_sbox_sched_tagpipe.sv
// rtl/aes_sbox_sched_tagpipe.sv - valid/tag delay line matching the S-box pipeline depth
module sbox_sched_tagpipe #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  // Only the valids are cleared; a tag is meaningless without its valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    for (int i = 1; i < DEPTH; i++) begin
      tag_q[i] <= tag_q[i-1];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/aes_sbox_sched.sv
// rtl/aes_sbox_sched.sv - feeds one shared block byte-by-byte through a pipelined masked S-box
// Optional feature: define AES_SBOX_SCHED_ZEROIZE_EN to wipe buffers after delivery and zero idle S-box input.
module aes_sbox_sched
  import aes_sbox_sched_pkg::*;
#(
  parameter int SHARES  = 2,
  parameter int N_BYTES = 16,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                        ClkxCI,
  input  logic                        RstxRI,
  input  logic                        InValidxSI,
  output logic                        InReadyxSO,
  input  logic [8*SHARES*N_BYTES-1:0] InDataxDI,
  output logic                        OutValidxSO,
  input  logic                        OutReadyxSI,
  output logic [8*SHARES*N_BYTES-1:0] OutDataxDO,
  input  logic                        RndValidxSI,
  output logic                        RndTakexSO,
  output logic [8*SHARES-1:0]         SboxXxDO,
  input  logic [8*SHARES-1:0]         SboxQxDI,
  output logic                        BusyxSO
);

  localparam int BW = 8 * SHARES;
  localparam int TW = $clog2(N_BYTES);
  localparam int CW = TW + 1;
  localparam logic [CW-1:0] N_LAST = CW'(N_BYTES - 1);
  localparam logic [CW-1:0] N_FULL = CW'(N_BYTES);

  state_t          state_q, state_d;
  logic [CW-1:0]   issue_cnt, collect_cnt;
  logic [TW-1:0]   issue_idx;
  logic [BW-1:0]   in_buf  [N_BYTES];
  logic [BW-1:0]   out_buf [N_BYTES];
  logic            accept, issue_fire, done_hs;
  logic            pipe_valid;
  logic [TW-1:0]   pipe_tag;
  logic [CW-1:0]   collect_next;

  assign issue_idx    = issue_cnt[TW-1:0];
  assign collect_next = collect_cnt + CW'(pipe_valid);

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    InReadyxSO  = 1'b0;
    OutValidxSO = 1'b0;
    RndTakexSO  = 1'b0;
    accept      = 1'b0;
    issue_fire  = 1'b0;
    done_hs     = 1'b0;
    case (state_q)
      IDLE: begin
        InReadyxSO = 1'b1;
        if (InValidxSI) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Without a fresh randomness set the slot becomes a bubble in the delay line.
        if (RndValidxSI) begin
          issue_fire = 1'b1;
          RndTakexSO = 1'b1;
          if (issue_cnt == N_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (collect_next == N_FULL) state_d = DONE;
      end
      DONE: begin
        OutValidxSO = 1'b1;
        if (OutReadyxSI) begin
          done_hs = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign BusyxSO = (state_q != IDLE);

  sbox_sched_tagpipe #(
    .DEPTH (LATENCY),
    .TAG_W (TW)
  ) u_tagpipe (
    .clk       (ClkxCI),
    .rst       (RstxRI),
    .in_valid  (issue_fire),
    .in_tag    (issue_idx),
    .out_valid (pipe_valid),
    .out_tag   (pipe_tag)
  );

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      issue_cnt   <= '0;
      collect_cnt <= '0;
      for (int b = 0; b < N_BYTES; b++) begin
        in_buf[b]  <= '0;
        out_buf[b] <= '0;
      end
    end else begin
      if (accept) begin
        issue_cnt   <= '0;
        collect_cnt <= '0;
        for (int b = 0; b < N_BYTES; b++) begin
          in_buf[b] <= InDataxDI[b*BW +: BW];
        end
      end
      if (issue_fire && issue_cnt < N_FULL) issue_cnt <= issue_cnt + 1'b1;
      // The tag pipe delivers each result at exactly LATENCY cycles after issue.
      if (pipe_valid) begin
        out_buf[pipe_tag] <= SboxQxDI;
        if (collect_cnt < N_FULL) collect_cnt <= collect_cnt + 1'b1;
      end
`ifdef AES_SBOX_SCHED_ZEROIZE_EN
      if (done_hs) begin
        for (int b = 0; b < N_BYTES; b++) begin
          in_buf[b]  <= '0;
          out_buf[b] <= '0;
        end
      end
`endif
    end
  end

`ifdef AES_SBOX_SCHED_ZEROIZE_EN
  assign SboxXxDO = issue_fire ? in_buf[issue_idx] : '0;
`else
  logic [BW-1:0] sbox_hold;

  always_ff @(posedge ClkxCI) begin
    if (RstxRI)          sbox_hold <= '0;
    else if (issue_fire) sbox_hold <= in_buf[issue_idx];
  end

  assign SboxXxDO = issue_fire ? in_buf[issue_idx] : sbox_hold;
`endif

  for (genvar b = 0; b < N_BYTES; b++) begin : g_out
    assign OutDataxDO[b*BW +: BW] = out_buf[b];
  end

endmodule
